// File: rtl/bus_scheduler.sv
// bus_scheduler: 16-cycle time-slot scheduler for the shared system bus / SRAM.
// Each 1 us CPU cycle is one frame: video fetch (slots 0-3), RPi/SPI access
// (slots 4-7), then the 6502 phase (slots 8-15). Every output is a register
// loaded with the value for the *next* slot, so off-chip strobes are glitch-free
// and line up exactly with slot_o.
module bus_scheduler #(
  parameter bit VIDEO_ENABLE = 1'b1,
  parameter int CPU_WE_START = 12
) (
  input  logic       clk_16_i,
  input  logic       reset_i,
  input  logic       spi_valid_i,
  input  logic       spi_rw_ni,
  output logic       spi_ready_o,
  output logic       spi_en_o,
  output logic       spi_rd_latch_o,
  input  logic       video_req_i,
  output logic       video_en_o,
  output logic       video_latch_o,
  input  logic       cpu_ready_i,
  input  logic       bus_rw_ni,
  input  logic       is_readonly_i,
  output logic       clk_cpu_o,
  output logic       cpu_en_o,
  output logic       ram_oe_o,
  output logic       ram_we_o,
  output logic [3:0] slot_o
);

  // ARMED covers slot 4 (address/data setup), ACCESS slots 5-6 (strobes),
  // DONE slot 7 (ready pulse, hold), WAIT_DROP until the bridge releases valid.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ACCESS,
    S_DONE,
    S_WAIT_DROP
  } spi_state_t;

  // Outputs are computed one slot ahead, so the write strobe decode starts
  // one slot before the first slot in which ram_we_o must be high.
  localparam logic [3:0] CPU_WE_FIRST = 4'(CPU_WE_START - 1);

  logic [3:0] slot;
  spi_state_t spi_state;
  logic       spi_rd;       // captured command direction: 1 = read
  logic       video_grant;  // video_req_i sampled at slot 15 of the previous frame
  logic       cpu_grant;    // cpu_ready_i sampled at slot 7 of this frame

  logic spi_accept;
  logic spi_strobe;
  logic video_oe;
  logic cpu_phase;
  logic cpu_rd;
  logic cpu_wr;

  assign slot_o = slot;

  // Decode, from the current slot and state, which strobes the next slot needs.
  // NOTE: combinational decode uses blocking '=' with every signal assigned on
  // each pass; all state lives in the clocked block below and uses '<='.
  always_comb begin
    spi_accept = (spi_state == S_IDLE) && (slot == 4'd3) && spi_valid_i;
    spi_strobe = (spi_state == S_ARMED) ||
                 ((spi_state == S_ACCESS) && (slot == 4'd5));
    video_oe   = video_grant && (slot <= 4'd1);
    cpu_phase  = cpu_grant && (slot >= 4'd8) && (slot <= 4'd14);
    cpu_rd     = cpu_phase && bus_rw_ni;
    cpu_wr     = cpu_phase && !bus_rw_ni && !is_readonly_i &&
                 (slot >= CPU_WE_FIRST) && (slot <= 4'd13);
  end

  // Slot counter, SPI handshake FSM, request sampling and registered outputs.
  always_ff @(posedge clk_16_i) begin
    if (reset_i) begin
      slot           <= 4'd0;
      spi_state      <= S_IDLE;
      spi_rd         <= 1'b0;
      video_grant    <= 1'b0;
      cpu_grant      <= 1'b0;
      spi_ready_o    <= 1'b0;
      spi_en_o       <= 1'b0;
      spi_rd_latch_o <= 1'b0;
      video_en_o     <= 1'b0;
      video_latch_o  <= 1'b0;
      clk_cpu_o      <= 1'b0;
      cpu_en_o       <= 1'b0;
      ram_oe_o       <= 1'b0;
      ram_we_o       <= 1'b0;
    end else begin
      slot <= slot + 4'd1;

      if (slot == 4'd15) video_grant <= VIDEO_ENABLE && video_req_i;
      if (slot == 4'd7)  cpu_grant   <= cpu_ready_i;

      case (spi_state)
        S_IDLE: begin
          if (spi_accept) begin
            spi_state <= S_ARMED;
            spi_rd    <= spi_rw_ni;
          end
        end
        S_ARMED:     spi_state <= S_ACCESS;
        S_ACCESS:    if (slot == 4'd6) spi_state <= S_DONE;
        S_DONE:      spi_state <= S_WAIT_DROP;
        // A level-held valid must be seen low once before a new command is taken.
        S_WAIT_DROP: if (!spi_valid_i) spi_state <= S_IDLE;
        default:     spi_state <= S_IDLE;
      endcase

      video_en_o     <= (slot == 4'd15) ? (VIDEO_ENABLE && video_req_i)
                                        : (video_grant && (slot <= 4'd2));
      video_latch_o  <= video_grant && (slot == 4'd1);

      spi_en_o       <= spi_accept || (spi_state == S_ARMED) ||
                        (spi_state == S_ACCESS);
      spi_rd_latch_o <= (spi_state == S_ACCESS) && (slot == 4'd5) && spi_rd;
      spi_ready_o    <= (spi_state == S_ACCESS) && (slot == 4'd6);

      // phi0 keeps running while the CPU is halted; only BE drops.
      clk_cpu_o      <= (slot >= 4'd7) && (slot <= 4'd14);
      cpu_en_o       <= (slot == 4'd7) ? cpu_ready_i : cpu_phase;

      // Slot ownership is disjoint and each owner drives one direction, so
      // ram_oe_o and ram_we_o can never be high together.
      ram_oe_o       <= video_oe || (spi_strobe && spi_rd) || cpu_rd;
      ram_we_o       <= (spi_strobe && !spi_rd) || cpu_wr;
    end
  end

endmodule

// File: tb/tb_bus_scheduler.sv
// tb_bus_scheduler: directed frame-by-frame vectors for bus_scheduler.
// Each frame is checked slot by slot against hand-written 16-bit masks
// (bit n = expected level in slot n).
module tb_bus_scheduler;

  logic       clk_16_i = 1'b0;
  logic       reset_i;
  logic       spi_valid_i;
  logic       spi_rw_ni;
  logic       spi_ready_o;
  logic       spi_en_o;
  logic       spi_rd_latch_o;
  logic       video_req_i;
  logic       video_en_o;
  logic       video_latch_o;
  logic       cpu_ready_i;
  logic       bus_rw_ni;
  logic       is_readonly_i;
  logic       clk_cpu_o;
  logic       cpu_en_o;
  logic       ram_oe_o;
  logic       ram_we_o;
  logic [3:0] slot_o;

  int n_checks = 0;
  int n_errors = 0;

  bus_scheduler #(
    .VIDEO_ENABLE(1'b1),
    .CPU_WE_START(12)
  ) dut (
    .clk_16_i       (clk_16_i),
    .reset_i        (reset_i),
    .spi_valid_i    (spi_valid_i),
    .spi_rw_ni      (spi_rw_ni),
    .spi_ready_o    (spi_ready_o),
    .spi_en_o       (spi_en_o),
    .spi_rd_latch_o (spi_rd_latch_o),
    .video_req_i    (video_req_i),
    .video_en_o     (video_en_o),
    .video_latch_o  (video_latch_o),
    .cpu_ready_i    (cpu_ready_i),
    .bus_rw_ni      (bus_rw_ni),
    .is_readonly_i  (is_readonly_i),
    .clk_cpu_o      (clk_cpu_o),
    .cpu_en_o       (cpu_en_o),
    .ram_oe_o       (ram_oe_o),
    .ram_we_o       (ram_we_o),
    .slot_o         (slot_o)
  );

  always #31 clk_16_i = ~clk_16_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_16_i);
    #1;
  endtask

  // Packed output order: spi_en oe we rd_latch ready cpu_en video_en video_latch clk_cpu
  function automatic logic [8:0] outs();
    return {spi_en_o, ram_oe_o, ram_we_o, spi_rd_latch_o, spi_ready_o,
            cpu_en_o, video_en_o, video_latch_o, clk_cpu_o};
  endfunction

  // Run one full frame from slot 0; optionally pull spi_valid_i low for one
  // slot, or drop cpu_ready_i mid-phase (-1 disables each).
  task automatic run_frame(input string tag,
                           input logic [15:0] m_spi_en, input logic [15:0] m_oe,
                           input logic [15:0] m_we, input logic [15:0] m_rdl,
                           input logic [15:0] m_rdy, input logic [15:0] m_cpu_en,
                           input logic [15:0] m_ven, input logic [15:0] m_vl,
                           input int valid_low_slot, input int cpu_drop_slot);
    logic [15:0] m_clk;
    logic [8:0]  exp;
    m_clk = 16'hFF00;
    for (int i = 0; i < 16; i++) begin
      exp = {m_spi_en[i], m_oe[i], m_we[i], m_rdl[i], m_rdy[i],
             m_cpu_en[i], m_ven[i], m_vl[i], m_clk[i]};
      check($sformatf("%s slot_o@%0d", tag, i), 32'(slot_o), 32'(i));
      check($sformatf("%s outs@%0d", tag, i), 32'(outs()), 32'(exp));
      if (i == valid_low_slot) spi_valid_i = 1'b0;
      else if (valid_low_slot >= 0 && i == valid_low_slot + 1) spi_valid_i = 1'b1;
      if (i == cpu_drop_slot) cpu_ready_i = 1'b0;
      tick();
    end
  endtask

  initial begin
    reset_i       = 1'b1;
    spi_valid_i   = 1'b0;
    spi_rw_ni     = 1'b1;
    video_req_i   = 1'b0;
    cpu_ready_i   = 1'b0;
    bus_rw_ni     = 1'b1;
    is_readonly_i = 1'b0;

    repeat (3) tick();
    check("reset slot_o", 32'(slot_o), 32'd0);
    check("reset outs", 32'(outs()), 32'd0);
    reset_i = 1'b0;

    // Idle frame: only phi0 toggles.
    run_frame("idle", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, -1, -1);

    // SPI read plus CPU read.
    spi_valid_i = 1'b1;
    spi_rw_ni   = 1'b1;
    cpu_ready_i = 1'b1;
    bus_rw_ni   = 1'b1;
    run_frame("spi_rd", 16'h00F0, 16'hFE60, 16'h0000, 16'h0040, 16'h0080,
              16'hFF00, 16'h0000, 16'h0000, -1, -1);

    // Valid held high for three frames: no repeat execution.
    for (int f = 0; f < 3; f++)
      run_frame($sformatf("held%0d", f), 16'h0000, 16'hFE00, 16'h0000, 16'h0000,
                16'h0000, 16'hFF00, 16'h0000, 16'h0000, -1, -1);

    // Valid drops for slot 1 only, command is a write; video requested for next frame.
    spi_rw_ni   = 1'b0;
    video_req_i = 1'b1;
    run_frame("spi_wr", 16'h00F0, 16'hFE00, 16'h0060, 16'h0000, 16'h0080,
              16'hFF00, 16'h0000, 16'h0000, 1, -1);

    // CPU halted during a write; video fetch owns slots 0-3.
    spi_valid_i = 1'b0;
    video_req_i = 1'b0;
    cpu_ready_i = 1'b0;
    bus_rw_ni   = 1'b0;
    run_frame("halt_vid", 16'h0000, 16'h0006, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h000F, 16'h0004, -1, -1);

    // CPU write to RAM; cpu_ready_i drop in slot 10 must be ignored.
    cpu_ready_i = 1'b1;
    run_frame("cpu_wr", 16'h0000, 16'h0000, 16'h7000, 16'h0000, 16'h0000,
              16'hFF00, 16'h0000, 16'h0000, -1, 10);

    // CPU write to read-only space: strobe suppressed.
    cpu_ready_i   = 1'b1;
    is_readonly_i = 1'b1;
    run_frame("cpu_ro", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'hFF00, 16'h0000, 16'h0000, -1, -1);

    // Reset in slot 5 of an SPI write.
    cpu_ready_i   = 1'b0;
    bus_rw_ni     = 1'b1;
    is_readonly_i = 1'b0;
    spi_valid_i   = 1'b1;
    spi_rw_ni     = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst slot_o", 32'(slot_o), 32'd5);
    check("pre_rst spi_en/we", 32'({spi_en_o, ram_we_o}), 32'b11);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("post_rst slot_o", 32'(slot_o), 32'd0);
    check("post_rst we/ready/spi_en", 32'({ram_we_o, spi_ready_o, spi_en_o}), 32'b000);

    // Still-high valid served in the first frame after reset, then not again.
    run_frame("rst_serve", 16'h00F0, 16'h0000, 16'h0060, 16'h0000, 16'h0080,
              16'h0000, 16'h0000, 16'h0000, -1, -1);
    run_frame("rst_held", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
              16'h0000, 16'h0000, 16'h0000, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
